// File: rtl/core_bus_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_bus_arb_pkg
// Description : Shared state encodings, timeout default and bus RW codes.
// Revision    : 1.0 - initial release
// ============================================================================
package core_bus_arb_pkg;

    localparam int  TIMEOUT_DEFAULT = 255;
    localparam int  BUS_W           = 32;
    localparam int  WDT_W           = 8;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GNT_IF = 2'd1,
        ST_GNT_EX = 2'd2
    } arb_state_t;

endpackage : core_bus_arb_pkg
`default_nettype wire

// File: rtl/core_bus_wdt.sv
`default_nettype none
// ============================================================================
// Module      : core_bus_wdt
// Description : Bus wait counter; flags expiry once TIMEOUT waits have elapsed.
// Revision    : 1.0 - initial release
// ============================================================================
module core_bus_wdt
    import core_bus_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [WDT_W-1:0] LIMIT = WDT_W'(TIMEOUT);

    logic [WDT_W-1:0] cnt_q;
    logic [WDT_W-1:0] cnt_d;

    assign expired = (cnt_q == LIMIT);

    // Saturates at the limit so a stuck enable can never wrap back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : core_bus_wdt
`default_nettype wire

// File: rtl/core_bus_arb.sv
`default_nettype none
// ============================================================================
// Module      : core_bus_arb
// Description : Fixed-priority (EX over IF) non-preemptive memory bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module core_bus_arb
    import core_bus_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req_in,
    input  logic [BUS_W-1:0] if_addr_in,
    output logic [BUS_W-1:0] if_data_out,
    output logic             if_valid_out,
    input  logic             ex_req_in,
    input  logic             ex_rw_in,
    input  logic [BUS_W-1:0] ex_addr_in,
    input  logic [BUS_W-1:0] ex_data_in,
    output logic [BUS_W-1:0] ex_data_out,
    output logic             ex_valid_out,
    output logic             bus_req_out,
    output logic             bus_rw_out,
    output logic [BUS_W-1:0] bus_addr_out,
    output logic [BUS_W-1:0] bus_data_out,
    input  logic [BUS_W-1:0] bus_data_in,
    input  logic             bus_ack_in,
    output logic             hold_flag_out,
    output logic             err_out
);

    arb_state_t       state_q,    state_d;
    logic             bus_req_q,  bus_req_d;
    logic             bus_rw_q,   bus_rw_d;
    logic [BUS_W-1:0] bus_addr_q, bus_addr_d;
    logic [BUS_W-1:0] bus_data_q, bus_data_d;
    logic [BUS_W-1:0] if_data_q,  if_data_d;
    logic             if_valid_q, if_valid_d;
    logic [BUS_W-1:0] ex_data_q,  ex_data_d;
    logic             ex_valid_q, ex_valid_d;
    logic             err_q,      err_d;

    logic             wdt_clr;
    logic             wdt_en;
    logic             wdt_expired;
    logic             unused_addr_lsbs;

    // Bus is word addressed; byte offsets are dropped on the way out.
    assign unused_addr_lsbs = ^{if_addr_in[1:0], ex_addr_in[1:0]};

    assign wdt_clr = (state_q == ST_IDLE);
    assign wdt_en  = (state_q != ST_IDLE) && !bus_ack_in;

    core_bus_wdt #(
        .TIMEOUT (TIMEOUT)
    ) u_wdt (
        .clk     (clk),
        .rst     (rst),
        .clr     (wdt_clr),
        .en      (wdt_en),
        .expired (wdt_expired)
    );

    always_comb begin
        state_d    = state_q;
        bus_req_d  = bus_req_q;
        bus_rw_d   = bus_rw_q;
        bus_addr_d = bus_addr_q;
        bus_data_d = bus_data_q;
        if_data_d  = if_data_q;
        if_valid_d = 1'b0;
        ex_data_d  = ex_data_q;
        ex_valid_d = 1'b0;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                // A requester is still presenting the finished access during
                // its valid cycle, so it is masked to avoid a double issue.
                if (ex_req_in && !ex_valid_q) begin
                    state_d    = ST_GNT_EX;
                    bus_req_d  = 1'b1;
                    bus_rw_d   = ex_rw_in;
                    bus_addr_d = {ex_addr_in[BUS_W-1:2], 2'b00};
                    bus_data_d = (ex_rw_in == RW_WRITE) ? ex_data_in : '0;
                end else if (if_req_in && !if_valid_q) begin
                    state_d    = ST_GNT_IF;
                    bus_req_d  = 1'b1;
                    bus_rw_d   = RW_READ;
                    bus_addr_d = {if_addr_in[BUS_W-1:2], 2'b00};
                    bus_data_d = '0;
                end
            end
            ST_GNT_IF, ST_GNT_EX: begin
                if (bus_ack_in || wdt_expired) begin
                    state_d    = ST_IDLE;
                    bus_req_d  = 1'b0;
                    bus_rw_d   = 1'b0;
                    bus_addr_d = '0;
                    bus_data_d = '0;
                    if (!bus_ack_in) begin
                        err_d = 1'b1;
                    end
                    if (state_q == ST_GNT_IF) begin
                        if_valid_d = 1'b1;
                        if_data_d  = bus_ack_in ? bus_data_in : '0;
                    end else begin
                        ex_valid_d = 1'b1;
                        if (!bus_ack_in) begin
                            ex_data_d = '0;
                        end else if (bus_rw_q == RW_READ) begin
                            ex_data_d = bus_data_in;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            bus_req_q  <= 1'b0;
            bus_rw_q   <= 1'b0;
            bus_addr_q <= '0;
            bus_data_q <= '0;
            if_data_q  <= '0;
            if_valid_q <= 1'b0;
            ex_data_q  <= '0;
            ex_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bus_req_q  <= bus_req_d;
            bus_rw_q   <= bus_rw_d;
            bus_addr_q <= bus_addr_d;
            bus_data_q <= bus_data_d;
            if_data_q  <= if_data_d;
            if_valid_q <= if_valid_d;
            ex_data_q  <= ex_data_d;
            ex_valid_q <= ex_valid_d;
            err_q      <= err_d;
        end
    end

    assign bus_req_out   = bus_req_q;
    assign bus_rw_out    = bus_rw_q;
    assign bus_addr_out  = bus_addr_q;
    assign bus_data_out  = bus_data_q;
    assign if_data_out   = if_data_q;
    assign if_valid_out  = if_valid_q;
    assign ex_data_out   = ex_data_q;
    assign ex_valid_out  = ex_valid_q;
    assign err_out       = err_q;
    assign hold_flag_out = (ex_req_in & ~ex_valid_q) | (if_req_in & ~if_valid_q);

endmodule : core_bus_arb
`default_nettype wire

// File: tb/tb_core_bus_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_bus_arb
// Description : Directed self-checking bench for core_bus_arb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_bus_arb;

    logic        clk;
    logic        rst;
    logic        if_req_in;
    logic [31:0] if_addr_in;
    logic [31:0] if_data_out;
    logic        if_valid_out;
    logic        ex_req_in;
    logic        ex_rw_in;
    logic [31:0] ex_addr_in;
    logic [31:0] ex_data_in;
    logic [31:0] ex_data_out;
    logic        ex_valid_out;
    logic        bus_req_out;
    logic        bus_rw_out;
    logic [31:0] bus_addr_out;
    logic [31:0] bus_data_out;
    logic [31:0] bus_data_in;
    logic        bus_ack_in;
    logic        hold_flag_out;
    logic        err_out;

    int checks = 0;
    int errors = 0;
    int n;

    core_bus_arb dut (
        .clk           (clk),
        .rst           (rst),
        .if_req_in     (if_req_in),
        .if_addr_in    (if_addr_in),
        .if_data_out   (if_data_out),
        .if_valid_out  (if_valid_out),
        .ex_req_in     (ex_req_in),
        .ex_rw_in      (ex_rw_in),
        .ex_addr_in    (ex_addr_in),
        .ex_data_in    (ex_data_in),
        .ex_data_out   (ex_data_out),
        .ex_valid_out  (ex_valid_out),
        .bus_req_out   (bus_req_out),
        .bus_rw_out    (bus_rw_out),
        .bus_addr_out  (bus_addr_out),
        .bus_data_out  (bus_data_out),
        .bus_data_in   (bus_data_in),
        .bus_ack_in    (bus_ack_in),
        .hold_flag_out (hold_flag_out),
        .err_out       (err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; if_req_in = 1'b0; if_addr_in = '0;
        ex_req_in = 1'b0; ex_rw_in = 1'b0; ex_addr_in = '0; ex_data_in = '0;
        bus_data_in = '0; bus_ack_in = 1'b0;
        tick; tick;
        chk("rst_bus_req", {31'd0, bus_req_out}, 32'd0);
        chk("rst_bus_addr", bus_addr_out, 32'd0);
        chk("rst_ex_data", ex_data_out, 32'd0);
        chk("rst_err", {31'd0, err_out}, 32'd0);
        chk("rst_valid", {30'd0, if_valid_out, ex_valid_out}, 32'd0);
        rst = 1'b1;
        tick;
        chk("idle_no_grant", {31'd0, bus_req_out}, 32'd0);

        // EX read of 0x106, ack on the second grant cycle
        ex_req_in = 1'b1; ex_rw_in = 1'b0; ex_addr_in = 32'h0000_0106;
        #1;
        chk("hold_req", {31'd0, hold_flag_out}, 32'd1);
        tick;
        chk("exr_bus_req", {31'd0, bus_req_out}, 32'd1);
        chk("exr_bus_addr", bus_addr_out, 32'h0000_0104);
        chk("exr_bus_rw", {31'd0, bus_rw_out}, 32'd0);
        chk("exr_hold", {31'd0, hold_flag_out}, 32'd1);
        tick;
        bus_ack_in = 1'b1; bus_data_in = 32'hDEAD_BEEF;
        #1;
        chk("exr_hold2", {31'd0, hold_flag_out}, 32'd1);
        tick;
        bus_ack_in = 1'b0; bus_data_in = '0;
        #1;
        chk("exr_valid", {31'd0, ex_valid_out}, 32'd1);
        chk("exr_data", ex_data_out, 32'hDEAD_BEEF);
        chk("exr_req_drop", {31'd0, bus_req_out}, 32'd0);
        chk("exr_hold_rel", {31'd0, hold_flag_out}, 32'd0);
        tick;
        chk("noreissue_req", {31'd0, bus_req_out}, 32'd0);
        chk("exr_valid_pulse", {31'd0, ex_valid_out}, 32'd0);
        chk("exr_data_held", ex_data_out, 32'hDEAD_BEEF);
        ex_req_in = 1'b0;
        tick;
        chk("noreissue_req2", {31'd0, bus_req_out}, 32'd0);

        // Simultaneous IF and EX write: EX first, IF after
        if_req_in = 1'b1; if_addr_in = 32'h0000_0000;
        ex_req_in = 1'b1; ex_rw_in = 1'b1; ex_addr_in = 32'h0000_0200; ex_data_in = 32'h1234_5678;
        tick;
        chk("prio_rw", {31'd0, bus_rw_out}, 32'd1);
        chk("prio_addr", bus_addr_out, 32'h0000_0200);
        chk("prio_wdata", bus_data_out, 32'h1234_5678);
        bus_ack_in = 1'b1; bus_data_in = 32'hAAAA_AAAA;
        tick;
        bus_ack_in = 1'b0; bus_data_in = '0;
        chk("exw_valid", {31'd0, ex_valid_out}, 32'd1);
        chk("exw_data_kept", ex_data_out, 32'hDEAD_BEEF);
        chk("exw_req_drop", {31'd0, bus_req_out}, 32'd0);
        ex_req_in = 1'b0; ex_rw_in = 1'b0;
        tick;
        chk("if_gnt_req", {31'd0, bus_req_out}, 32'd1);
        chk("if_gnt_rw", {31'd0, bus_rw_out}, 32'd0);
        chk("if_gnt_data", bus_data_out, 32'd0);

        // EX read raised while IF is in flight: no preemption
        ex_req_in = 1'b1; ex_addr_in = 32'h0000_0300;
        tick;
        chk("nopre_req", {31'd0, bus_req_out}, 32'd1);
        chk("nopre_addr", bus_addr_out, 32'h0000_0000);
        chk("nopre_ex_valid", {31'd0, ex_valid_out}, 32'd0);
        bus_ack_in = 1'b1; bus_data_in = 32'hCAFE_0001;
        tick;
        bus_ack_in = 1'b0; bus_data_in = '0;
        chk("if_valid", {31'd0, if_valid_out}, 32'd1);
        chk("if_data", if_data_out, 32'hCAFE_0001);
        if_req_in = 1'b0;
        tick;
        chk("ex_after_if_req", {31'd0, bus_req_out}, 32'd1);
        chk("ex_after_if_addr", bus_addr_out, 32'h0000_0300);
        chk("pre_to_err", {31'd0, err_out}, 32'd0);

        // Slave never acks: timeout abort
        n = 0;
        while (!ex_valid_out && n < 400) begin
            tick;
            n++;
        end
        chk("to_cycles", n, 32'd256);
        chk("to_ex_data", ex_data_out, 32'd0);
        chk("to_err", {31'd0, err_out}, 32'd1);
        chk("to_req_drop", {31'd0, bus_req_out}, 32'd0);
        ex_req_in = 1'b0;

        // Normal IF read after the error
        if_req_in = 1'b1; if_addr_in = 32'h0000_000B;
        tick;
        chk("post_err_if_addr", bus_addr_out, 32'h0000_0008);
        bus_ack_in = 1'b1; bus_data_in = 32'h55AA_55AA;
        tick;
        bus_ack_in = 1'b0; bus_data_in = '0;
        chk("post_err_if_data", if_data_out, 32'h55AA_55AA);
        chk("post_err_if_valid", {31'd0, if_valid_out}, 32'd1);
        if_req_in = 1'b0;
        tick;
        chk("if_valid_pulse", {31'd0, if_valid_out}, 32'd0);
        chk("err_sticky", {31'd0, err_out}, 32'd1);

        // Ack while idle is ignored
        bus_ack_in = 1'b1; bus_data_in = 32'hFFFF_FFFF;
        tick;
        bus_ack_in = 1'b0; bus_data_in = '0;
        chk("idle_ack_valid", {30'd0, if_valid_out, ex_valid_out}, 32'd0);
        chk("idle_ack_data", if_data_out, 32'h55AA_55AA);

        // Reset during GNT_EX
        ex_req_in = 1'b1; ex_rw_in = 1'b1; ex_addr_in = 32'h0000_0010; ex_data_in = 32'h1;
        tick;
        chk("pre_rst_req", {31'd0, bus_req_out}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_req", {31'd0, bus_req_out}, 32'd0);
        chk("async_rst_err", {31'd0, err_out}, 32'd0);
        chk("async_rst_data", ex_data_out, 32'd0);
        ex_req_in = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        chk("rel_ex_valid", {31'd0, ex_valid_out}, 32'd0);
        chk("rel_req", {31'd0, bus_req_out}, 32'd0);
        tick;
        chk("rel_ex_valid2", {31'd0, ex_valid_out}, 32'd0);
        chk("rel_err", {31'd0, err_out}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_core_bus_arb
`default_nettype wire
